pwm_multi: RTL and testbench

PWM_MULTI -- requirements
Module: pwm_multi

---
 rtl/pwm_pkg.sv | 20 ++
 rtl/pwm_cnt.sv | 99 +++++++++
 rtl/pwm_multi.sv | 90 +++++++++
 tb/tb_pwm_multi.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// pwm_pkg -- shared defaults, counter/duty types and counter direction encoding
// Revision: 1.0
// ============================================================================
package pwm_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_NCH   = 4;

    typedef logic [DEF_WIDTH-1:0] duty_t;
    typedef logic [DEF_WIDTH-1:0] cnt_t;

    typedef enum logic [0:0] {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage : pwm_pkg
`default_nettype wire

// File: rtl/pwm_cnt.sv
`default_nettype none
// ============================================================================
// pwm_cnt -- period counter shared by all channels; flags the active-load cycle.
// PWM_CENTER_ALIGN_EN selects up/down counting with the load at the valley.
// Revision: 1.0
// ============================================================================
module pwm_cnt
    import pwm_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] cnt,
    output logic             load,
    output logic             bypass
);

    localparam logic [WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] CNT_MAX  = '1;

    logic [WIDTH-1:0] cnt_nxt;

`ifdef PWM_CENTER_ALIGN_EN

    dir_e dir;
    dir_e dir_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir <= DIR_UP;
            cnt <= CNT_ZERO;
        end else begin
            dir <= dir_nxt;
            cnt <= cnt_nxt;
        end
    end

    // Up 0..MAX, then down to 1; the next 0 opens a new period.
    always_comb begin
        dir_nxt = dir;
        cnt_nxt = cnt;
        if (!en) begin
            dir_nxt = DIR_UP;
            cnt_nxt = CNT_ZERO;
        end else if (dir == DIR_UP) begin
            if (cnt == CNT_MAX) begin
                dir_nxt = DIR_DOWN;
                cnt_nxt = cnt - CNT_ONE;
            end else begin
                cnt_nxt = cnt + CNT_ONE;
            end
        end else begin
            cnt_nxt = cnt - CNT_ONE;
            if (cnt == CNT_ONE) begin
                dir_nxt = DIR_UP;
            end
        end
    end

    // The valley is both the load point and the first compared sample.
    always_comb begin
        load   = en && (cnt == CNT_ZERO);
        bypass = load;
    end

`else

    logic run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run <= 1'b0;
            cnt <= CNT_ZERO;
        end else begin
            run <= en;
            cnt <= cnt_nxt;
        end
    end

    always_comb begin
        cnt_nxt = CNT_ZERO;
        if (en) begin
            cnt_nxt = cnt + CNT_ONE;
        end
    end

    // First enabled cycle compares against the freshly loaded value directly.
    always_comb begin
        load   = en && ((cnt == CNT_MAX) || !run);
        bypass = en && !run;
    end

`endif

endmodule : pwm_cnt
`default_nettype wire

// File: rtl/pwm_multi.sv
`default_nettype none
// ============================================================================
// pwm_multi -- NCH-channel PWM with shadowed duty words updated at period bounds.
// PWM_CENTER_ALIGN_EN enables centre-aligned (up/down) operation.
// Revision: 1.0
// ============================================================================
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NCH   = DEF_NCH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [NCH*WIDTH-1:0] duty,
    input  logic                 duty_vld,
    output logic [NCH-1:0]       PWM_sig,
    output logic                 period_start
);

    localparam logic [WIDTH-1:0] CNT_ZERO = '0;

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cmp_cnt;
    logic             load;
    logic             bypass;
    logic [NCH-1:0]   pwm_nxt;

    pwm_cnt #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .cnt    (cnt),
        .load   (load),
        .bypass (bypass)
    );

`ifdef PWM_CENTER_ALIGN_EN
    // cnt > MAX-active  <=>  ~cnt < active: pulse centred on the top of the count.
    assign cmp_cnt = ~cnt;
`else
    assign cmp_cnt = cnt;
`endif

    generate
        for (genvar i = 0; i < NCH; i++) begin : g_ch
            logic [WIDTH-1:0] duty_in;
            logic [WIDTH-1:0] shadow;
            logic [WIDTH-1:0] active;
            logic [WIDTH-1:0] load_val;
            logic [WIDTH-1:0] cmp_val;

            assign duty_in  = duty[i*WIDTH +: WIDTH];
            // A strobe on the load cycle goes straight to active.
            assign load_val = duty_vld ? duty_in : shadow;
            assign cmp_val  = bypass ? load_val : active;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    shadow <= CNT_ZERO;
                    active <= CNT_ZERO;
                end else begin
                    if (duty_vld) begin
                        shadow <= duty_in;
                    end
                    if (load) begin
                        active <= load_val;
                    end
                end
            end

            assign pwm_nxt[i] = (cmp_cnt < cmp_val);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PWM_sig      <= '0;
            period_start <= 1'b0;
        end else begin
            PWM_sig      <= en ? pwm_nxt : '0;
            period_start <= en && (cnt == CNT_ZERO);
        end
    end

endmodule : pwm_multi
`default_nettype wire

// File: tb/tb_pwm_multi.sv
`default_nettype none
// ============================================================================
// tb_pwm_multi -- scoreboard bench: per-period high counts checked against queue.
// Revision: 1.0
// ============================================================================
module tb_pwm_multi;

    localparam int WIDTH = 8;
    localparam int NCH   = 4;
`ifdef PWM_CENTER_ALIGN_EN
    localparam int PER = 510;
`else
    localparam int PER = 256;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 en;
    logic [NCH*WIDTH-1:0] duty;
    logic                 duty_vld;
    logic [NCH-1:0]       pwm;
    logic                 period_start;

    always #5 clk = ~clk;

    pwm_multi #(
        .WIDTH (WIDTH),
        .NCH   (NCH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .duty         (duty),
        .duty_vld     (duty_vld),
        .PWM_sig      (pwm),
        .period_start (period_start)
    );

    typedef struct packed {
        logic [15:0]      len;
        logic [3:0][15:0] h;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    function automatic exp_t mk(input int l, input int h0, input int h1, input int h2, input int h3);
        exp_t e;
        e.len  = 16'(l);
        e.h[0] = 16'(h0);
        e.h[1] = 16'(h1);
        e.h[2] = 16'(h2);
        e.h[3] = 16'(h3);
        return e;
    endfunction

    // Monitor: accumulate high cycles between period_start pulses.
    bit open_w = 1'b0;
    int acc_len;
    int acc[4];
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n || !en) begin
            open_w = 1'b0;
        end else begin
            if (period_start) begin
                if (open_w) begin
                    if (q.size() > 0) begin
                        e = q.pop_front();
                        chk("period_len", acc_len, int'(e.len));
                        for (int c = 0; c < NCH; c++)
                            chk($sformatf("high_ch%0d", c), acc[c], int'(e.h[c]));
                    end else begin
                        chk("unexpected_period", 1, 0);
                    end
                end
                open_w  = 1'b1;
                acc_len = 0;
                acc     = '{default: 0};
            end
            if (open_w) begin
                acc_len++;
                for (int c = 0; c < NCH; c++)
                    if (pwm[c]) acc[c]++;
            end
        end
    end

    task automatic wait_ps(input int bound, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (period_start !== 1'b1 && n < bound);
        chk(tag, int'(period_start), 1);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        duty     = '0;
        duty_vld = 1'b0;
        cyc(3);
        @(negedge clk);
        chk("reset_pwm", int'(pwm), 0);
        chk("reset_ps", int'(period_start), 0);
        cyc(1);
        rst_n = 1'b1;
        cyc(1);

`ifdef PWM_CENTER_ALIGN_EN
        duty     = {8'd64, 8'd64, 8'd64, 8'd64};
        duty_vld = 1'b1;
        cyc(1);
        duty_vld = 1'b0;
        en       = 1'b1;
        q.push_back(mk(PER, 127, 127, 127, 127));
        q.push_back(mk(PER, 127, 127, 127, 127));
        wait_ps(3, "c_first_ps");
        repeat (191) @(negedge clk);
        chk("c_pos191", int'(pwm), 0);
        @(negedge clk);
        chk("c_pos192", int'(pwm), 15);
        repeat (126) @(negedge clk);
        chk("c_pos318", int'(pwm), 15);
        @(negedge clk);
        chk("c_pos319", int'(pwm), 0);
        wait_ps(PER + 10, "c_p2_ps");
        wait_ps(PER + 10, "c_p3_ps");
`else
        // Scenario: static duties 255/128/64/0
        duty     = {8'd0, 8'd64, 8'd128, 8'd255};
        duty_vld = 1'b1;
        cyc(1);
        duty_vld = 1'b0;
        en       = 1'b1;
        q.push_back(mk(PER, 255, 128, 64, 0));
        q.push_back(mk(PER, 255, 128, 64, 0));
        wait_ps(3, "p1_ps");
        wait_ps(PER + 10, "p2_ps");

        // Mid-period shadow update at cnt=10
        q.push_back(mk(PER, 32, 128, 64, 0));
        cyc(9);
        duty[7:0] = 8'd32;
        duty_vld  = 1'b1;
        cyc(1);
        duty_vld  = 1'b0;
        wait_ps(PER + 10, "p3_ps");

        // Strobe on the wrap cycle
        cyc(254);
        duty[15:8] = 8'd200;
        duty_vld   = 1'b1;
        q.push_back(mk(PER, 32, 200, 64, 0));
        cyc(1);
        duty_vld   = 1'b0;
        wait_ps(PER + 10, "p4_ps");

        // en dropped at cnt=20 for 20 cycles
        wait_ps(PER + 10, "p5_ps");
        cyc(19);
        en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("en_off_pwm", int'(pwm), 0);
        chk("en_off_ps", int'(period_start), 0);
        repeat (18) @(posedge clk);
        @(negedge clk);
        chk("en_off_hold_pwm", int'(pwm), 0);
        cyc(1);
        en = 1'b1;
        q.push_back(mk(PER, 32, 200, 64, 0));
        wait_ps(3, "restart_ps");

        // Async reset at cnt=100 with a pending shadow value
        wait_ps(PER + 10, "p7_ps");
        cyc(89);
        duty     = {8'd99, 8'd99, 8'd99, 8'd99};
        duty_vld = 1'b1;
        cyc(1);
        duty_vld = 1'b0;
        cyc(9);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_pwm", int'(pwm), 0);
        chk("async_rst_ps", int'(period_start), 0);
        cyc(2);
        rst_n = 1'b1;
        q.push_back(mk(PER, 0, 0, 0, 0));
        q.push_back(mk(PER, 0, 0, 0, 0));
        wait_ps(3, "post_rst_ps");
        wait_ps(PER + 10, "p9_ps");
        cyc(49);
        duty     = {8'd40, 8'd30, 8'd20, 8'd10};
        duty_vld = 1'b1;
        q.push_back(mk(PER, 10, 20, 30, 40));
        cyc(1);
        duty_vld = 1'b0;
        wait_ps(PER + 10, "p10_ps");
        wait_ps(PER + 10, "p11_ps");
`endif

        cyc(1);
        en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("final_off_pwm", int'(pwm), 0);
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_pwm_multi
`default_nettype wire
